// File: rtl/data_responder.sv
// CPU data-port responder: word RAM plus a small MMIO block (LEDs, switches, hex,
// free-running cycle counter, scratch). Loads have a fixed one-cycle latency.
module data_responder #(
  parameter int ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [15:0] data_in,
  input  logic        wren,
  output logic [15:0] q,
  input  logic [9:0]  sw_in,
  output logic [9:0]  led_out,
  output logic [15:0] hex_out,
  output logic        bus_err
);
  localparam int          DEPTH = 1 << ADDR_BITS;
  localparam logic [15:0] A_LED = 16'hFF00;
  localparam logic [15:0] A_SW  = 16'hFF01;
  localparam logic [15:0] A_HEX = 16'hFF02;
  localparam logic [15:0] A_CNT = 16'hFF03;
  localparam logic [15:0] A_SCR = 16'hFF04;

  logic [15:0]          mem [DEPTH];
  logic [9:0]           sw_s1, sw_s2;
  logic [15:0]          scratch, cnt, rdata;
  logic                 in_ram, mapped;
  logic [ADDR_BITS-1:0] ram_idx;

  assign in_ram  = {1'b0, address} < 17'(DEPTH);
  assign ram_idx = address[ADDR_BITS-1:0];

  // RAM has no reset so it maps onto block memory; old data on read-during-write.
  always_ff @(posedge clk) begin
    if (!reset && wren && in_ram) mem[ram_idx] <= data_in;
  end

  always_comb begin
    rdata  = '0;
    mapped = 1'b1;
    if (in_ram) rdata = mem[ram_idx];
    else begin
      case (address)
        A_LED:   rdata = {6'b0, led_out};
        A_SW:    rdata = {6'b0, sw_s2};
        A_HEX:   rdata = hex_out;
        A_CNT:   rdata = cnt;
        A_SCR:   rdata = scratch;
        default: mapped = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q       <= '0;
      led_out <= '0;
      hex_out <= '0;
      scratch <= '0;
      cnt     <= '0;
      bus_err <= 1'b0;
      sw_s1   <= '0;
      sw_s2   <= '0;
    end else begin
      sw_s1 <= sw_in;
      sw_s2 <= sw_s1;
      q     <= rdata;
      cnt   <= (wren && address == A_CNT) ? 16'h0000 : cnt + 16'h0001;
      if (!mapped) bus_err <= 1'b1;
      if (wren) begin
        case (address)
          A_LED:   led_out <= data_in[9:0];
          A_HEX:   hex_out <= data_in;
          A_SCR:   scratch <= data_in;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_data_responder.sv
// Randomized bench for data_responder against an address-map level reference model.
module tb_data_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] address = '0, data_in = '0, q, hex_out;
  logic        wren = 1'b0, bus_err;
  logic [9:0]  sw_in = '0, led_out;

  int checks = 0, errors = 0;

  data_responder #(.ADDR_BITS(8)) dut (
    .clk(clk), .reset(reset), .address(address), .data_in(data_in), .wren(wren),
    .q(q), .sw_in(sw_in), .led_out(led_out), .hex_out(hex_out), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Reference model: map contents, counter as edges elapsed since last clear.
  logic [15:0] m_ram [256];
  logic [9:0]  m_led;
  logic [15:0] m_hex, m_scr, exp_q;
  logic        m_err;
  int          cyc, clr;
  logic [9:0]  sw_edge [$];

  function automatic bit is_mapped(input logic [15:0] a);
    return (a < 16'd256) || (a >= 16'hFF00 && a <= 16'hFF04);
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] a);
    if (a < 16'd256) return m_ram[a[7:0]];
    case (a)
      16'hFF00: return {6'b0, m_led};
      16'hFF01: return (sw_edge.size() >= 2) ? {6'b0, sw_edge[sw_edge.size()-2]} : 16'h0;
      16'hFF02: return m_hex;
      16'hFF03: return 16'((cyc - clr) & 32'hFFFF);
      16'hFF04: return m_scr;
      default:  return 16'h0;
    endcase
  endfunction

  // Drives one access (called at posedge+1), advances one edge, updates the model.
  task automatic cycle(input logic [15:0] a, input logic [15:0] d, input bit w);
    address = a; data_in = d; wren = w;
    exp_q = model_read(a);
    if (!is_mapped(a)) m_err = 1'b1;
    if (w) begin
      if (a < 16'd256) m_ram[a[7:0]] = d;
      else if (a == 16'hFF00) m_led = d[9:0];
      else if (a == 16'hFF02) m_hex = d;
      else if (a == 16'hFF03) clr = cyc + 1;
      else if (a == 16'hFF04) m_scr = d;
    end
    sw_edge.push_back(sw_in);
    cyc++;
    @(posedge clk); #1;
    wren = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_led = '0; m_hex = '0; m_scr = '0; m_err = 1'b0;
    cyc = 0; clr = 0; sw_edge.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #3;
    reset = 1'b1; #1;
    checks++;
    if (q !== 16'h0 || led_out !== 10'h0 || hex_out !== 16'h0 || bus_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: q=%h led=%h hex=%h err=%b, want all 0", q, led_out, hex_out, bus_err);
    end
    do_reset();
    cycle(16'hFF03, 16'h0, 1'b0);
    checks++;
    if (q !== 16'h0000) begin errors++; $display("FAIL reset_counter: got %h want 0000", q); end
    cycle(16'hFF04, 16'h0, 1'b0);
    checks++;
    if (q !== 16'h0000) begin errors++; $display("FAIL reset_scratch: got %h want 0000", q); end
  endtask

  task automatic test_ram();
    for (int i = 0; i < 256; i++) cycle(16'(i), 16'($urandom), 1'b1);
    cycle(16'h0005, 16'h1234, 1'b1);
    cycle(16'h0005, 16'h0, 1'b0);
    checks++;
    if (q !== 16'h1234) begin errors++; $display("FAIL ram_store_load: got %h want 1234", q); end
    for (int i = 0; i < 40; i++) begin
      logic [15:0] a;
      a = 16'($urandom_range(0, 255));
      cycle(a, 16'($urandom), 1'($urandom));
      checks++;
      if (q !== exp_q) begin errors++; $display("FAIL ram_random: addr %h got %h want %h", a, q, exp_q); end
    end
  endtask

  task automatic test_rdw();
    cycle(16'h0010, 16'hAAAA, 1'b1);
    cycle(16'h0010, 16'h5555, 1'b1);
    checks++;
    if (q !== 16'hAAAA) begin errors++; $display("FAIL rdw_old: got %h want AAAA", q); end
    cycle(16'h0010, 16'h0, 1'b0);
    checks++;
    if (q !== 16'h5555) begin errors++; $display("FAIL rdw_new: got %h want 5555", q); end
  endtask

  task automatic test_mmio();
    cycle(16'hFF00, 16'hFFFF, 1'b1);
    checks++;
    if (led_out !== 10'h3FF) begin errors++; $display("FAIL led_write: got %h want 3ff", led_out); end
    cycle(16'hFF00, 16'h0, 1'b0);
    checks++;
    if (q !== 16'h03FF) begin errors++; $display("FAIL led_read: got %h want 03ff", q); end
    cycle(16'hFF02, 16'hBEEF, 1'b1);
    checks++;
    if (hex_out !== 16'hBEEF) begin errors++; $display("FAIL hex_write: got %h want beef", hex_out); end
    cycle(16'hFF04, 16'hC0DE, 1'b1);
    cycle(16'hFF04, 16'h0, 1'b0);
    checks++;
    if (q !== 16'hC0DE) begin errors++; $display("FAIL scratch: got %h want c0de", q); end
    cycle(16'hFF01, 16'hFFFF, 1'b1);
    checks++;
    if (bus_err !== 1'b0) begin errors++; $display("FAIL sw_write_err: got %b want 0", bus_err); end
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0) sw_in = 10'($urandom);
      cycle(16'hFF01, 16'($urandom), 1'($urandom));
      checks++;
      if (q !== exp_q) begin errors++; $display("FAIL switch_sync: got %h want %h", q, exp_q); end
    end
  endtask

  task automatic test_counter();
    do_reset();
    repeat (16'h40) cycle(16'h0000, 16'h0, 1'b0);
    cycle(16'hFF03, 16'h9999, 1'b1);
    checks++;
    if (q !== 16'h0040) begin errors++; $display("FAIL counter_pre_clear: got %h want 0040", q); end
    cycle(16'hFF03, 16'h0, 1'b0);
    checks++;
    if (q !== 16'h0000) begin errors++; $display("FAIL counter_clear: got %h want 0000", q); end
    do_reset();
    repeat (16'hFFFF) cycle(16'h0001, 16'h0, 1'b0);
    cycle(16'hFF03, 16'h0, 1'b0);
    checks++;
    if (q !== 16'hFFFF) begin errors++; $display("FAIL counter_max: got %h want ffff", q); end
    cycle(16'hFF03, 16'h0, 1'b0);
    checks++;
    if (q !== 16'h0000) begin errors++; $display("FAIL counter_wrap: got %h want 0000", q); end
  endtask

  task automatic test_unmapped();
    cycle(16'h00AB, 16'h7777, 1'b1);
    cycle(16'h8000, 16'h0, 1'b0);
    checks++;
    if (q !== 16'h0000 || bus_err !== 1'b1) begin
      errors++; $display("FAIL unmapped_read: q=%h err=%b want 0000/1", q, bus_err);
    end
    cycle(16'h01AB, 16'h1111, 1'b1);
    cycle(16'h00AB, 16'h0, 1'b0);
    checks++;
    if (q !== 16'h7777 || bus_err !== 1'b1) begin
      errors++; $display("FAIL unmapped_write: q=%h err=%b want 7777/1", q, bus_err);
    end
    do_reset();
    checks++;
    if (bus_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", bus_err); end
  endtask

  task automatic test_async_reset();
    cycle(16'hFF00, 16'h0155, 1'b1);
    checks++;
    if (led_out !== 10'h155) begin errors++; $display("FAIL led_pre_reset: got %h want 155", led_out); end
    cycle(16'h0005, 16'h0, 1'b0);
    #2 reset = 1'b1; #1;
    checks++;
    if (led_out !== 10'h0) begin errors++; $display("FAIL async_reset: got %h want 000", led_out); end
    address = 16'hFF00; data_in = 16'h03FF; wren = 1'b1;
    @(posedge clk); #1;
    address = 16'h0005; data_in = 16'hDEAD;
    do_reset();
    wren = 1'b0;
    cycle(16'hFF00, 16'h0, 1'b0);
    checks++;
    if (q !== 16'h0000 || led_out !== 10'h0) begin
      errors++; $display("FAIL reset_write_led: q=%h led=%h want 0", q, led_out);
    end
    cycle(16'h0005, 16'h0, 1'b0);
    checks++;
    if (q !== exp_q) begin errors++; $display("FAIL reset_write_ram: got %h want %h", q, exp_q); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic [15:0] a;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 16'($urandom_range(0, 255));
        4, 5, 6, 7: a = 16'hFF00 + 16'($urandom_range(0, 4));
        8:          a = 16'($urandom_range(256, 16'hFEFF));
        default:    a = 16'hFF05 + 16'($urandom_range(0, 250));
      endcase
      if ($urandom_range(0, 7) == 0) sw_in = 10'($urandom);
      cycle(a, 16'($urandom), ($urandom_range(0, 3) == 0) && (a != 16'hFF03 || $urandom_range(0, 3) == 0));
      checks++;
      if (q !== exp_q || bus_err !== m_err || led_out !== m_led || hex_out !== m_hex) begin
        errors++;
        $display("FAIL random: addr %h q=%h/%h err=%b/%b led=%h/%h hex=%h/%h (got/want)",
                 a, q, exp_q, bus_err, m_err, led_out, m_led, hex_out, m_hex);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_rdw();
    test_mmio();
    test_unmapped();
    test_async_reset();
    test_random();
    test_counter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_responder.md
DATA_RESPONDER -- requirements
Module: data_responder

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 8, meaning log2 of the RAM depth in 16-bit words (256 words at the default).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port address, input, 16 bits: word address of the CPU data-port access, sampled every cycle.
REQ-005 The block SHALL have port data_in, input, 16 bits: store data, valid when wren=1.
REQ-006 The block SHALL have port wren, input, 1 bit: store strobe, one access per cycle.
REQ-007 The block SHALL have port q, output, 16 bits: registered load data for the address sampled at the previous edge.
REQ-008 The block SHALL have port sw_in, input, 10 bits: asynchronous switch inputs.
REQ-009 The block SHALL have port led_out, output, 10 bits: LED register contents.
REQ-010 The block SHALL have port hex_out, output, 16 bits: hex-display register contents.
REQ-011 The block SHALL have port bus_err, output, 1 bit: sticky flag for accesses to unmapped addresses.

Function
REQ-012 The block SHALL decode the address map as follows:
- 0x0000 .. 2^ADDR_BITS-1: RAM, read/write.
- 0xFF00: LED register, read/write; bits [9:0] are stored and bits [15:10] read as 0.
- 0xFF01: switches, read-only; reads return {6'b0, synchronised sw}.
- 0xFF02: hex register, read/write, 16 bits.
- 0xFF03: cycle counter, read; any write clears it.
- 0xFF04: scratch register, read/write, 16 bits.
REQ-013 Read latency SHALL be exactly 1 cycle: q after edge N equals the contents at address(N), sampled at edge N, as they were before any write at edge N (read-during-write returns old data).
REQ-014 A write (wren=1) SHALL update the addressed location at that edge; the new value is visible to a read sampled at the next edge.
REQ-015 q SHALL be updated every cycle regardless of wren; there is no hold or enable.
REQ-016 Writes to 0xFF01 SHALL have no effect and SHALL NOT set bus_err.
REQ-017 Any access, read or write, to an address outside the map SHALL:
- read as 0x0000;
- have no effect when it is a write;
- set bus_err at that edge; bus_err stays set until reset.
REQ-018 The cycle counter SHALL be 16 bits and increment by 1 every cycle, wrapping from 0xFFFF to 0x0000.
REQ-019 A write to 0xFF03 SHALL make the counter 0x0000 after that edge, taking priority over the increment.
REQ-020 A read of 0xFF03 SHALL return the counter value before the increment at the sampling edge.
REQ-021 sw_in SHALL pass through a 2-flop synchroniser; a switch change SHALL be readable no earlier than 2 edges after the change.
REQ-022 led_out and hex_out SHALL reflect their registers directly, updating at the write edge.
REQ-023 RAM contents SHALL be 0 at power-up and SHALL NOT be cleared by reset.

Reset
REQ-024 While reset=1, the following SHALL be held at 0:
- q, led_out, hex_out;
- the scratch register, the counter, bus_err;
- both synchroniser stages.
REQ-025 Writes presented while reset=1 SHALL be ignored for registers and RAM.
REQ-026 After reset deasserts, the counter SHALL read 0x0000 for an access sampled at the first edge.
REQ-027 Reset asserted mid-operation SHALL take effect immediately, without waiting for an edge, and no partial state SHALL survive in registers.

Verification
REQ-028 RAM store/load: write 0x1234 to 0x0005, then read 0x0005 the next cycle -> q=0x1234 one edge after the read is sampled.
REQ-029 Read-during-write: RAM 0x0010 holds 0xAAAA; write 0x5555 with address 0x0010 -> q=0xAAAA; a read of 0x0010 at the next edge -> q=0x5555.
REQ-030 MMIO: write 0xFFFF to 0xFF00 -> led_out=0x3FF and a readback gives 0x03FF; write 0xBEEF to 0xFF02 -> hex_out=0xBEEF.
REQ-031 Counter: after 0xFFFF free-run edges from reset -> it reads 0xFFFF, then wraps to 0x0000; write to 0xFF03 at counter 0x0040 -> the next read gives 0x0000.
REQ-032 Unmapped access: read 0x8000 -> q=0x0000 and bus_err=1; a later valid access leaves bus_err=1; reset clears it to 0.
REQ-033 Async reset: assert reset between edges while led_out=0x155 -> led_out=0 immediately; a write present during reset -> no change after deassert.
